// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: memory handshake bundle between the sequencer and memory.
//   memData  - read data returned by memory (instruction fetch / load data)
//   mem_ack  - memory completion for the current request
//   mem_req  - request strobe, held until mem_ack
//   mem_we   - 1 = write (STOR), 0 = read
//   addr_sel - address source: 0 = PC, 1 = regA
// master modport = sequencer side, slave modport = memory side.
interface cpu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] memData;
  logic             mem_ack;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;

  modport master (input memData, mem_ack, output mem_req, mem_we, addr_sel);
  modport slave  (output memData, mem_ack, input mem_req, mem_we, addr_sel);
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB).
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   mem        - memory handshake (cpu_sequencer_if.master)
//   instructionOp/immediate/regAddA/regAddB/flagOp - fields decoded from IR
//   ALUOp..LUIOp - datapath controls, asserted in EXEC / WB
//   state_out  - current state encoding for debug
module cpu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cpu_sequencer_if.master        mem,
  output logic [7:0]             instructionOp,
  output logic [7:0]             immediate,
  output logic [3:0]             regAddA,
  output logic [3:0]             regAddB,
  output logic [3:0]             flagOp,
  output logic [3:0]             ALUOp,
  output logic [1:0]             shiftOp,
  output logic [2:0]             busOp,
  output logic                   immMUX,
  output logic                   regWrite,
  output logic                   pcAdd,
  output logic                   pcJump,
  output logic                   pcBranch,
  output logic                   flagWrite,
  output logic                   LUIOp,
  output logic [2:0]             state_out
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] ir;

  logic [3:0] op, rd, ext, rs;
  logic       isLoad, isStor;

  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign ext = ir[7:4];
  assign rs  = ir[3:0];

  assign instructionOp = {op, ext};
  assign immediate     = ir[7:0];
  assign regAddA       = rs;
  assign regAddB       = rd;
  assign flagOp        = rd;
  assign state_out     = state;

  assign isLoad = (op == 4'b0100) && (ext == 4'b0000);
  assign isStor = (op == 4'b0100) && (ext == 4'b0100);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      state <= stateNext;
      if (state == FETCH && mem.mem_ack) ir <= mem.memData;
    end
  end

  // Outputs are qualified by reset so mem_req and controls fall the moment
  // reset goes low, without waiting for an edge.
  always_comb begin
    stateNext    = FETCH;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ALUOp        = 4'd0;
    shiftOp      = 2'd0;
    busOp        = 3'd0;
    immMUX       = 1'b0;
    regWrite     = 1'b0;
    pcAdd        = 1'b0;
    pcJump       = 1'b0;
    pcBranch     = 1'b0;
    flagWrite    = 1'b0;
    LUIOp        = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          mem.mem_req = 1'b1;
          stateNext   = mem.mem_ack ? DECODE : FETCH;
        end
        DECODE: stateNext = (isLoad || isStor) ? MEM : EXEC;
        EXEC: begin
          stateNext = FETCH;
          case (op)
            4'b0000: begin // R-type ALU
              ALUOp = ext; busOp = 3'd2; regWrite = 1'b1; flagWrite = 1'b1; pcAdd = 1'b1;
            end
            4'b1000: begin // shift
              shiftOp = ext[1:0]; immMUX = ext[2]; busOp = 3'd3; regWrite = 1'b1; pcAdd = 1'b1;
            end
            4'b1111: begin // LUI
              LUIOp = 1'b1; immMUX = 1'b1; busOp = 3'd0; regWrite = 1'b1; pcAdd = 1'b1;
            end
            4'b1100: pcBranch = 1'b1; // Bcond
            4'b0100: begin
              if (ext == 4'b1000) begin // JAL: link PC+1
                busOp = 3'd4; regWrite = 1'b1; pcJump = 1'b1;
              end else if (ext == 4'b1100) begin // Jcond
                pcJump = 1'b1;
              end else begin // unused ext codes behave as NOP
                pcAdd = 1'b1;
              end
            end
            default: begin // immediate ALU, opcode doubles as ALU function
              ALUOp = op; immMUX = 1'b1; busOp = 3'd2; regWrite = 1'b1; flagWrite = 1'b1; pcAdd = 1'b1;
            end
          endcase
        end
        MEM: begin
          mem.mem_req  = 1'b1;
          mem.addr_sel = 1'b1;
          mem.mem_we   = isStor;
          stateNext    = mem.mem_ack ? WB : MEM;
        end
        WB: begin
          stateNext = FETCH;
          pcAdd     = 1'b1;
          if (isLoad) begin
            busOp    = 3'd1;
            regWrite = 1'b1;
          end
        end
        default: stateNext = FETCH;
      endcase
    end
  end

endmodule
